e203_dtcm_icb2ram: RTL
======================

# e203_dtcm_icb2ram

Initiator side of the DTCM SRAM interface. It accepts single-beat read/write commands on an ICB-style valid/ready bus from the LSU/DTCM arbiter and drives the SRAM macro pins: `cs`, `we`, `addr`, `wem`, `din` and `dout`, plus the `sd`/`ds`/`ls` power controls. It returns in-order responses with a one-entry hold buffer. It also manages light-sleep entry and exit for the macro.

## Interface
Parameters:
- `AW`, 32: ICB byte-address width.
- `RAM_AW`, 14: SRAM word-address width (64 KB with DW=32).
- `DW`, 32: data width.
- `MW`, 4: write-mask width (DW/8).
- `LS_IDLE`, 16: idle cycles before light sleep is entered; must be ≥1.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `ls_en`  in  1  enables automatic light sleep.
- `cmd_valid`  in  1  command valid.
- `cmd_ready`  out  1  command accepted when both valid and ready are high.
- `cmd_addr`  in  AW  byte address; bits [1:0] are ignored.
- `cmd_read`  in  1  1 = read, 0 = write.
- `cmd_wdata`  in  DW  write data.
- `cmd_wmask`  in  MW  byte enables.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accepted.
- `rsp_rdata`  out  DW  read data; 0 for writes and errors.
- `rsp_err`  out  1  out-of-range access.
- `ram_cs`, `ram_we`  out  1  SRAM select and write enable.
- `ram_addr`  out  RAM_AW  SRAM word address.
- `ram_wem`  out  MW  SRAM write mask.
- `ram_din`  out  DW  SRAM write data.
- `ram_dout`  in  DW  SRAM read data; valid the cycle after a read `cs`, and stable until the next `cs`.
- `ram_sd`, `ram_ds`  out  1  tied to 0.
- `ram_ls`  out  1  light sleep; registered.

## Operation
- `cmd_fire = cmd_valid & cmd_ready`.
- `cmd_ready = !hold_vld & !ram_ls`. It is registered-only and has no combinational path from `rsp_ready`.
- Out of range when `cmd_addr[AW-1:RAM_AW+2] != 0`. Such a command is accepted, produces no `ram_cs`, and returns `rsp_err=1`.
- In-range command:
  - `ram_cs = 1`, `ram_we = !cmd_read`, `ram_addr = cmd_addr[RAM_AW+1:2]`.
  - `ram_wem = cmd_wmask` on writes, 0 on reads.
  - `ram_din = cmd_wdata`.
  - The ram_* outputs are combinational from the command.
- Stage s1 (registers `s1_vld`, `s1_read`, `s1_err`) tracks the command fired last cycle.
  - s1 drains whenever `hold_vld = 0`.
  - It goes to the output if `rsp_ready = 1`; otherwise it is captured into hold, together with `ram_dout` if it was a read.
- Response mux:
  - If `hold_vld`, present hold.
  - Else, if `s1_vld`, present s1, with `rdata = s1_read & !s1_err ? ram_dout : 0`.
  - `rsp_valid = hold_vld | s1_vld`.
- When hold is full, s1 waits. This is safe because `cmd_ready = 0`, so no new `cs` occurs and `ram_dout` stays stable. After hold pops, s1 is presented the next cycle.
- Responses are strictly in command order. At most 2 commands are outstanding (s1 + hold).
- Power FSM with states ACTIVE and SLEEP:
  - In ACTIVE, the idle counter increments each cycle with `!cmd_valid & !s1_vld & !hold_vld`, and clears otherwise.
  - At `count == LS_IDLE-1` with `ls_en = 1`, the next state is SLEEP (`ram_ls = 1`).
  - In SLEEP, `cmd_valid = 1` or `ls_en = 0` returns to ACTIVE the next cycle (`ram_ls = 0`). A command is then accepted one cycle after the wake at the earliest.
  - The counter saturates and clears on entering ACTIVE.

## Timing
- Reset values:
  - `rsp_valid = 0`, `cmd_ready = 1`.
  - `ram_cs = 0`, `ram_we = 0`, `ram_ls = 0`.
  - `s1_vld = 0`, `hold_vld = 0`, FSM = ACTIVE, counter = 0.
  - `ram_sd = 0`, `ram_ds = 0`.
- Latency: response on cycle N+1 for a command fired on cycle N, when not stalled.
- Throughput: one command per cycle while `rsp_ready = 1`.
- Wake from SLEEP: `cmd_valid` at cycle N → `ram_ls` falls at N+1 → fire at N+1 → response at N+2.
- Reset mid-transaction drops s1, hold and any pending response. The SRAM contents are unaffected.
- `rsp_valid` stays high and `rsp_*` stay stable until `rsp_ready`.

## Structure
- Shared package/defines: `E203_DTCM_RAM_AW`, `E203_DTCM_RAM_DW` and `E203_DTCM_RAM_MW` supply the defaults, plus the power-state encodings PWR_ACTIVE=1'b0 and PWR_SLEEP=1'b1.
- One sub-module: `e203_dtcm_ls_ctrl`, containing the power FSM and idle counter. Its outputs are `ram_ls` and a `wake_block` signal.
- Flops use the codebase's `sirv_gnrl_dffr`/`dfflr` primitives.

## Test plan
- Back-to-back: write 0xDEADBEEF mask 4'hF to addr 0x10, then read 0x10 with `rsp_ready = 1` → responses on consecutive cycles; the read returns 0xDEADBEEF and `ram_addr = 4`.
- Partial write: mask 4'b0010 with data 0x0000AB00 over an address holding 0x11223344, then read → 0x1122AB44.
- Backpressure: 3 reads issued with `rsp_ready = 0` for 4 cycles → `cmd_ready` falls after 2 fires. Responses then arrive in order with correct data, and there are no `ram_cs` pulses during the stall.
- Error: read of `cmd_addr = 0x0001_0000` (RAM_AW = 14) → no `ram_cs`; `rsp_err = 1`, `rdata = 0` on the next cycle.
- Light sleep: `ls_en = 1` and idle for 16 cycles → `ram_ls = 1`. A read is presented → `cmd_ready = 0` for one cycle, `ram_ls` falls, fire, then the response. With `ls_en = 0`, `ram_ls` never rises.
- Reset: assert `rst_n` low while hold is full → all outputs return to their reset values, and `cmd_ready = 1` after release.

Source files
------------

// File: rtl/e203_dtcm_icb2ram_pkg.sv
// Shared DTCM SRAM geometry defaults and power-state encodings.
package e203_dtcm_icb2ram_pkg;

    localparam int E203_DTCM_RAM_AW = 14;
    localparam int E203_DTCM_RAM_DW = 32;
    localparam int E203_DTCM_RAM_MW = E203_DTCM_RAM_DW / 8;

    typedef enum logic {
        PWR_ACTIVE = 1'b0,
        PWR_SLEEP  = 1'b1
    } pwr_state_e;

    // Read data is forwarded only for in-range reads.
    function automatic logic rsp_data_live(input logic is_read, input logic is_err);
        return is_read & ~is_err;
    endfunction

endpackage

// File: rtl/e203_dtcm_ls_ctrl.sv
// Light-sleep controller: idle counter and ACTIVE/SLEEP FSM for the DTCM macro.
module e203_dtcm_ls_ctrl
    import e203_dtcm_icb2ram_pkg::*;
#(
    parameter int LS_IDLE = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ls_en_i,
    input  logic cmd_valid_i,
    input  logic busy_i,
    output logic ram_ls_o,
    output logic wake_block_o
);

    localparam int CW = (LS_IDLE > 1) ? $clog2(LS_IDLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LS_IDLE - 1);

    pwr_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          ls_q;
    logic          idle_s;

    assign idle_s = ~cmd_valid_i & ~busy_i;

    // Power FSM with saturating idle counter; ls_q is the registered sleep pin.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= PWR_ACTIVE;
            cnt_q   <= {CW{1'b0}};
            ls_q    <= 1'b0;
        end else begin
            case (state_q)
                PWR_ACTIVE: begin
                    if (idle_s && ls_en_i && (cnt_q == CNT_LAST)) begin
                        state_q <= PWR_SLEEP;
                        ls_q    <= 1'b1;
                    end else if (!idle_s) begin
                        cnt_q <= {CW{1'b0}};
                    end else if (cnt_q != CNT_LAST) begin
                        cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_q <= cnt_q;
                    end
                end
                PWR_SLEEP: begin
                    if (cmd_valid_i || !ls_en_i) begin
                        state_q <= PWR_ACTIVE;
                        ls_q    <= 1'b0;
                        cnt_q   <= {CW{1'b0}};
                    end else begin
                        ls_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= PWR_ACTIVE;
                    ls_q    <= 1'b0;
                    cnt_q   <= {CW{1'b0}};
                end
            endcase
        end
    end

    // Commands are held off for the whole sleep period, including the wake cycle.
    assign ram_ls_o     = ls_q;
    assign wake_block_o = ls_q;

endmodule

// File: rtl/e203_dtcm_icb2ram.sv
// ICB-to-SRAM bridge for the DTCM: single-beat commands, in-order responses
// through one s1 stage plus a one-entry hold buffer, and light-sleep control.
module e203_dtcm_icb2ram
    import e203_dtcm_icb2ram_pkg::*;
#(
    parameter int AW      = 32,
    parameter int RAM_AW  = E203_DTCM_RAM_AW,
    parameter int DW      = E203_DTCM_RAM_DW,
    parameter int MW      = E203_DTCM_RAM_MW,
    parameter int LS_IDLE = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ls_en,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [AW-1:0]     cmd_addr,
    input  logic              cmd_read,
    input  logic [DW-1:0]     cmd_wdata,
    input  logic [MW-1:0]     cmd_wmask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_err,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [MW-1:0]     ram_wem,
    output logic [DW-1:0]     ram_din,
    input  logic [DW-1:0]     ram_dout,
    output logic              ram_sd,
    output logic              ram_ds,
    output logic              ram_ls
);

    logic          cmd_fire_s, in_range_s, wake_block_s, unused_addr_s;
    logic          s1_vld_q, s1_read_q, s1_err_q;
    logic          s1_vld_d, s1_read_d, s1_err_d;
    logic          hold_vld_q, hold_err_q, hold_vld_d, hold_err_d;
    logic [DW-1:0] hold_rdata_q, hold_rdata_d, s1_rdata_s;

    assign in_range_s    = (cmd_addr[AW-1:RAM_AW+2] == {(AW-RAM_AW-2){1'b0}});
    assign unused_addr_s = ^cmd_addr[1:0];
    assign cmd_ready     = ~hold_vld_q & ~wake_block_s;
    assign cmd_fire_s    = cmd_valid & cmd_ready;

    assign ram_cs   = cmd_fire_s & in_range_s;
    assign ram_we   = ram_cs & ~cmd_read;
    assign ram_addr = cmd_addr[RAM_AW+1:2];
    assign ram_din  = cmd_wdata;
    assign ram_sd   = 1'b0;
    assign ram_ds   = 1'b0;

    always_comb begin
        if (ram_we) begin
            ram_wem = cmd_wmask;
        end else begin
            ram_wem = {MW{1'b0}};
        end
    end

    // ram_dout stays valid for s1 until the next cs, which cannot happen while hold is full.
    assign s1_rdata_s = (s1_vld_q && rsp_data_live(s1_read_q, s1_err_q)) ? ram_dout : {DW{1'b0}};

    always_comb begin
        s1_vld_d     = s1_vld_q;
        s1_read_d    = s1_read_q;
        s1_err_d     = s1_err_q;
        hold_vld_d   = hold_vld_q;
        hold_rdata_d = hold_rdata_q;
        hold_err_d   = hold_err_q;
        if (!hold_vld_q) begin
            s1_vld_d  = cmd_fire_s;
            s1_read_d = cmd_read;
            s1_err_d  = ~in_range_s;
        end else begin
            s1_vld_d  = s1_vld_q;
        end
        if (hold_vld_q) begin
            hold_vld_d = ~rsp_ready;
        end else if (s1_vld_q && !rsp_ready) begin
            hold_vld_d   = 1'b1;
            hold_rdata_d = s1_rdata_s;
            hold_err_d   = s1_err_q;
        end else begin
            hold_vld_d = 1'b0;
        end
    end

    // Response pipeline state; reset drops anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q     <= 1'b0;
            s1_read_q    <= 1'b0;
            s1_err_q     <= 1'b0;
            hold_vld_q   <= 1'b0;
            hold_rdata_q <= {DW{1'b0}};
            hold_err_q   <= 1'b0;
        end else begin
            s1_vld_q     <= s1_vld_d;
            s1_read_q    <= s1_read_d;
            s1_err_q     <= s1_err_d;
            hold_vld_q   <= hold_vld_d;
            hold_rdata_q <= hold_rdata_d;
            hold_err_q   <= hold_err_d;
        end
    end

    assign rsp_valid = hold_vld_q | s1_vld_q;

    always_comb begin
        if (hold_vld_q) begin
            rsp_rdata = hold_rdata_q;
            rsp_err   = hold_err_q;
        end else begin
            rsp_rdata = s1_rdata_s;
            rsp_err   = s1_vld_q & s1_err_q;
        end
    end

    e203_dtcm_ls_ctrl #(
        .LS_IDLE(LS_IDLE)
    ) u_ls_ctrl (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .ls_en_i     (ls_en),
        .cmd_valid_i (cmd_valid),
        .busy_i      (s1_vld_q | hold_vld_q),
        .ram_ls_o    (ram_ls),
        .wake_block_o(wake_block_s)
    );

endmodule
